// File: rtl/lab1_response_checker.sv
// Registered response checker for the Lab1 function F(A,B,C,D): compares observed
// samples to a golden truth table, tracks vector coverage and yields a pass/fail/timeout verdict.
module lab1_response_checker #(
    parameter int                    N_IN        = 4,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED    = 16'h6996,
    parameter int                    TIMEOUT_CYC = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sample_valid,
    input  logic [N_IN-1:0]        sample_vec,
    input  logic                   sample_f,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [7:0]             err_count,
    output logic                   first_err_valid,
    output logic [N_IN-1:0]        first_err_vec,
    output logic [(1<<N_IN)-1:0]   coverage
);
    localparam int NV    = 1 << N_IN;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       err_q, err_d;
    logic             fev_q, fev_d;
    logic [N_IN-1:0]  fvec_q, fvec_d;
    logic [NV-1:0]    cov_q, cov_d;
    logic [NV-1:0]    vec_hit;
    logic             mismatch;

    // One-hot decode of the sampled vector, used to set its coverage bit.
    generate
        for (genvar gi = 0; gi < NV; gi++) begin : g_hit
            assign vec_hit[gi] = (sample_vec == N_IN'(gi));
        end
    endgenerate

    assign mismatch = (sample_f != EXPECTED[sample_vec]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        fev_d     = fev_q;
        fvec_d    = fvec_q;
        cov_d     = cov_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    err_d     = '0;
                    fev_d     = 1'b0;
                    fvec_d    = '0;
                    cov_d     = '0;
                end
            end
            ST_RUN: begin
                if (sample_valid) begin
                    cov_d = cov_q | vec_hit;
                    if (mismatch) begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        if (!fev_q) begin
                            fev_d  = 1'b1;
                            fvec_d = sample_vec;
                        end
                    end
                end
                // Completion is checked before timeout so a covering sample on the last cycle still passes.
                if (&cov_d) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 8'd0);
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            fev_q     <= 1'b0;
            fvec_q    <= '0;
            cov_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            fev_q     <= fev_d;
            fvec_q    <= fvec_d;
            cov_q     <= cov_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fvec_q;
    assign coverage        = cov_q;

endmodule
